reuse_fifo_buf: RTL
===================

// Module: reuse_fifo_buf
// PURPOSE
// - Local operand buffer (abuf/lbuf flavour) in each array core; sits between the vlink/hlink write path and the core MAC.
// - Consumes the controller's ren / reuse_ren / reuse_rst strobes and returns empty/full, plus read data one cycle later.
// - Supports K-loop reuse: entries can be replayed through a reuse pointer and are freed only by a popping read.
// PARAMETERS
// - DATA_WIDTH   16   bits per entry (matches ARR_GBUS_DATA slice)
// - DEPTH        8    entries; power of two, >=2
// - PTR_W        $clog2(DEPTH)   derived, do not override
// PORTS
// - clk          in   1           clock, all state on posedge
// - rst          in   1           asynchronous, active-high reset
// - wen          in   1           push wdata (vlink_wen/hlink_wen)
// - wdata        in   DATA_WIDTH  write data
// - ren          in   1           pop: read entry at rd_ptr, free it
// - reuse_ren    in   1           replay: read entry at reuse_ptr, no free
// - reuse_rst    in   1           reuse_ptr <= rd_ptr
// - rdata        out  DATA_WIDTH  read data, valid when rvalid
// - rvalid       out  1           1-cycle-late strobe for an accepted read
// - empty        out  1           count==0 (registered)
// - full         out  1           count==DEPTH (registered)
// - count        out  PTR_W+1     occupied entries
// BEHAVIOUR
// - Reset: rd_ptr=wr_ptr=reuse_ptr=0, count=0, empty=1, full=0, rvalid=0, rdata=0; memory not cleared.
// - Pointers are PTR_W+1 bits (wrap bit); full/empty decided by count, not pointer compare.
// - Write accepted iff wen && !full (full as registered this cycle); a write while full is dropped even with a same-cycle ren.
// - Read port is single; priority ren > reuse_ren. ren accepted iff !empty; reuse_ren accepted iff reuse_ptr!=wr_ptr and no accepted ren.
// - Accepted ren: rdata<=mem[rd_ptr], rd_ptr+1, count-1. If reuse_ptr==rd_ptr it advances too (reuse_ptr never trails rd_ptr).
// - Accepted reuse_ren: rdata<=mem[reuse_ptr], reuse_ptr+1; count unchanged.
// - rvalid=1 exactly the cycle after an accepted read; otherwise 0, rdata holds its last value.
// - reuse_rst: reuse_ptr<=rd_ptr (post-pop value if ren same cycle); overrides a same-cycle reuse_ren advance; the read itself still occurs.
// - Simultaneous accepted write and pop: count unchanged.
// - Write into empty buffer: readable next cycle only, no same-cycle bypass; a ren in that cycle is ignored.
// - Wrap-around: pointer index uses low PTR_W bits; wrap bit toggles at DEPTH.
// - Asserting rst mid-operation clears all state immediately; in-flight rvalid is killed.
// CONFIGURATION
// - REUSE_FIFO_ERR_EN defined: adds outputs err_ovf/err_udf (1 bit each), sticky until rst.
//   - err_ovf sets on wen&&full; err_udf sets on ren&&empty, or reuse_ren with reuse_ptr==wr_ptr.
// - Not defined: ports absent; illegal requests silently ignored as above.
// STRUCTURE
// - Shared package (buf_pkg): typedef buf_ptr_t, buf_cnt_t, enum BUF_RD_SEL {RD_NONE, RD_POP, RD_REUSE}.
// - Sub-module buf_regfile_2p: 1W1R register file, synchronous read, no reset on array.
// - Top holds pointers, counter, flags, read-select decode.
// TESTING (DATA_WIDTH=8, DEPTH=4)
// - Reset, push 0x11,0x22,0x33,0x44 -> full=1 after 4th; 5th push 0x55 dropped; 4 ren -> rdata 11,22,33,44 each one cycle after ren; empty=1.
// - Push A0..A2; reuse_ren x3 -> A0,A1,A2, count=3; reuse_rst; reuse_ren x3 -> A0,A1,A2 again; ren x3 -> A0..A2, empty.
// - ren and reuse_ren same cycle with 2 entries -> only pop serviced, count-1, reuse_ptr moves with rd_ptr.
// - Full (4 entries) + wen + ren same cycle -> write dropped, count=3; push 6 more across pops to verify wrap order.
// - ren on empty / wen+ren into empty -> rvalid stays 0, count=1 after; with REUSE_FIFO_ERR_EN err_udf=1 sticky.
// - rst asserted the cycle after ren -> rvalid=0, empty=1, count=0 immediately (async).

Source files
------------

// File: rtl/buf_pkg.sv
// Shared types for the reuse FIFO operand buffer.
// Default geometry types plus the read-port select encoding.
package buf_pkg;

    localparam int BUF_DEPTH = 8;
    localparam int BUF_PTR_W = $clog2(BUF_DEPTH);

    typedef logic [BUF_PTR_W:0] buf_ptr_t;
    typedef logic [BUF_PTR_W:0] buf_cnt_t;

    typedef enum logic [1:0] {
        RD_NONE  = 2'd0,
        RD_POP   = 2'd1,
        RD_REUSE = 2'd2
    } buf_rd_sel_e;

endpackage

// File: rtl/buf_regfile_2p.sv
// 1W1R register file with registered read data.
// The array itself is never reset; only the read register is.
module buf_regfile_2p #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: storage array, no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: capture on accepted read, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/reuse_fifo_buf.sv
// Local operand FIFO with a replay (reuse) pointer for K-loop reuse.
// Optional REUSE_FIFO_ERR_EN adds sticky err_ovf/err_udf outputs.
module reuse_fifo_buf
    import buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic                  reuse_ren,
    input  logic                  reuse_rst,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  full,
`ifdef REUSE_FIFO_ERR_EN
    output logic                  err_ovf,
    output logic                  err_udf,
`endif
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] reuse_ptr;

    logic [PTR_W:0] rd_ptr_nxt;
    logic [PTR_W:0] wr_ptr_nxt;
    logic [PTR_W:0] reuse_ptr_nxt;
    logic [PTR_W:0] count_nxt;

    logic           wr_acc;
    logic           rd_acc;
    logic [PTR_W-1:0] rd_addr;
    buf_rd_sel_e    rd_sel;

    assign wr_acc = wen && !full;

    // Read-port arbitration: pop wins over replay.
    always_comb begin
        rd_sel  = RD_NONE;
        rd_addr = rd_ptr[PTR_W-1:0];
        if (ren && !empty) begin
            rd_sel  = RD_POP;
            rd_addr = rd_ptr[PTR_W-1:0];
        end else if (reuse_ren && (reuse_ptr != wr_ptr)) begin
            rd_sel  = RD_REUSE;
            rd_addr = reuse_ptr[PTR_W-1:0];
        end
    end

    assign rd_acc = (rd_sel != RD_NONE);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        reuse_ptr_nxt = reuse_ptr;
        count_nxt     = count;
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_ONE;
        end
        unique case (rd_sel)
            RD_POP: begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
                if (reuse_ptr == rd_ptr) begin
                    reuse_ptr_nxt = reuse_ptr + PTR_ONE;
                end
            end
            RD_REUSE: reuse_ptr_nxt = reuse_ptr + PTR_ONE;
            default: ;
        endcase
        if (reuse_rst) begin
            reuse_ptr_nxt = rd_ptr_nxt;
        end
        if (wr_acc && (rd_sel != RD_POP)) begin
            count_nxt = count + PTR_ONE;
        end else if (!wr_acc && (rd_sel == RD_POP)) begin
            count_nxt = count - PTR_ONE;
        end
    end

    // Pointer, count, flag and read-strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            reuse_ptr <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rvalid    <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            reuse_ptr <= reuse_ptr_nxt;
            count     <= count_nxt;
            empty     <= (count_nxt == '0);
            full      <= (count_nxt == CNT_FULL);
            rvalid    <= rd_acc;
        end
    end

`ifdef REUSE_FIFO_ERR_EN
    // Sticky error flags for dropped or illegal requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wen && full) begin
                err_ovf <= 1'b1;
            end
            if ((ren && empty) ||
                (reuse_ren && (reuse_ptr == wr_ptr))) begin
                err_udf <= 1'b1;
            end
        end
    end
`endif

    buf_regfile_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[PTR_W-1:0]),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_addr),
        .rdata (rdata)
    );

endmodule
